// File: rtl/bridge_pkg.sv
// bridge_pkg: shared state encoding, response codes and default widths for the AHB-to-APB bridge.
package bridge_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_PSEL_W = 32;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        WR_SETUP,
        WR_ENABLE,
        RD_SETUP,
        RD_ENABLE
    } state_t;

    // States in which the AHB side is allowed to finish a cycle and present a new address.
    function automatic logic ready_state(input state_t s);
        return (s == IDLE) || (s == WR_ENABLE) || (s == RD_ENABLE);
    endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: APB master FSM that turns decoded AHB transfers into SETUP+ENABLE APB cycles.
//   Hclk/Hresetn : clock, asynchronous active-low reset
//   valid, Haddr, Hwrite, tempselx : AHB address phase (sampled only while Hreadyout=1)
//   Hwdata       : AHB write data (data phase)
//   Prdata       : APB read data, passed to Hrdata during RD_ENABLE
//   Pselx, Penable, Pwrite, Paddr, Pwdata : registered APB outputs
//   Hreadyout, Hrdata, Hresp : AHB response (Hresp always OKAY)
module apb_fsm_controller
    import bridge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PSEL_W = DEF_PSEL_W
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [PSEL_W-1:0] tempselx,
    input  logic [DATA_W-1:0] Prdata,
    output logic [PSEL_W-1:0] Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Hresp
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [PSEL_W-1:0] sel_q;
    logic              accept;

    assign accept    = valid && (tempselx != '0);
    assign Hreadyout = ready_state(state);
    assign Hrdata    = (state == RD_ENABLE) ? Prdata : '0;
    assign Hresp     = HRESP_OKAY;

    // Reads go straight to SETUP from the sampled address phase; writes need one
    // extra cycle for Hwdata, so their address/select are held in addr_q/sel_q.
    // Pwdata itself is the write-data capture register.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            Pselx   <= '0;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            Paddr   <= '0;
            Pwdata  <= '0;
        end else begin
            unique case (state)
                IDLE, WR_ENABLE, RD_ENABLE: begin
                    Penable <= 1'b0;
                    if (accept) begin
                        addr_q <= Haddr;
                        sel_q  <= tempselx;
                        if (Hwrite) begin
                            state <= WWAIT;
                            Pselx <= '0;
                        end else begin
                            state  <= RD_SETUP;
                            Pselx  <= tempselx;
                            Paddr  <= Haddr;
                            Pwrite <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        Pselx <= '0;
                    end
                end
                WWAIT: begin
                    state   <= WR_SETUP;
                    Pselx   <= sel_q;
                    Paddr   <= addr_q;
                    Pwrite  <= 1'b1;
                    Pwdata  <= Hwdata;
                    Penable <= 1'b0;
                end
                WR_SETUP: begin
                    state   <= WR_ENABLE;
                    Penable <= 1'b1;
                end
                RD_SETUP: begin
                    state   <= RD_ENABLE;
                    Penable <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    Pselx   <= '0;
                    Penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed self-checking bench for apb_fsm_controller.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        valid;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic [31:0] tempselx;
    logic [31:0] Prdata;
    logic [31:0] Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;

    int total = 0;
    int bad   = 0;

    apb_fsm_controller dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .Hwdata    (Hwdata),
        .tempselx  (tempselx),
        .Prdata    (Prdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        Hresetn  = 1'b0;
        valid    = 1'b0;
        Haddr    = '0;
        Hwrite   = 1'b0;
        Hwdata   = '0;
        tempselx = '0;
        Prdata   = '0;
        repeat (2) cyc();
        chk("rst_hready", Hreadyout, 1);
        chk("rst_psel", Pselx, 0);
        chk("rst_penable", Penable, 0);
        chk("rst_pwrite", Pwrite, 0);
        chk("rst_paddr", Paddr, 0);
        chk("rst_pwdata", Pwdata, 0);
        chk("rst_hrdata", Hrdata, 0);
        chk("rst_hresp", Hresp, 0);
        Hresetn = 1'b1;

        // valid with no slave selected is treated as idle
        valid = 1'b1; Haddr = 32'h8000_0020; tempselx = 0;
        cyc();
        chk("nosel_hready", Hreadyout, 1);
        chk("nosel_psel", Pselx, 0);
        cyc();
        chk("nosel_penable", Penable, 0);
        chk("nosel_psel2", Pselx, 0);

        // single read
        valid = 1'b1; Haddr = 32'h8000_0010; tempselx = 32'h1; Hwrite = 1'b0; Prdata = 32'hDEAD_BEEF;
        cyc();
        valid = 1'b0; tempselx = 0; Haddr = 0;
        chk("rd_setup_psel", Pselx, 1);
        chk("rd_setup_paddr", Paddr, 32'h8000_0010);
        chk("rd_setup_pwrite", Pwrite, 0);
        chk("rd_setup_penable", Penable, 0);
        chk("rd_setup_hready", Hreadyout, 0);
        chk("rd_setup_hrdata", Hrdata, 0);
        cyc();
        chk("rd_en_penable", Penable, 1);
        chk("rd_en_hready", Hreadyout, 1);
        chk("rd_en_hrdata", Hrdata, 32'hDEAD_BEEF);
        chk("rd_en_psel", Pselx, 1);
        cyc();
        chk("rd_idle_psel", Pselx, 0);
        chk("rd_idle_penable", Penable, 0);
        chk("rd_idle_paddr_hold", Paddr, 32'h8000_0010);
        chk("rd_idle_hrdata", Hrdata, 0);

        // single write: two wait states
        valid = 1'b1; Haddr = 32'h8400_0004; Hwrite = 1'b1; tempselx = 32'h2;
        cyc();
        valid = 1'b0; tempselx = 0; Hwrite = 1'b0; Haddr = 0; Hwdata = 32'h1234_5678;
        chk("wr_wait_hready", Hreadyout, 0);
        chk("wr_wait_psel", Pselx, 0);
        cyc();
        Hwdata = 0;
        chk("wr_setup_hready", Hreadyout, 0);
        chk("wr_setup_pwdata", Pwdata, 32'h1234_5678);
        chk("wr_setup_pwrite", Pwrite, 1);
        chk("wr_setup_psel", Pselx, 2);
        chk("wr_setup_paddr", Paddr, 32'h8400_0004);
        chk("wr_setup_penable", Penable, 0);
        cyc();
        chk("wr_en_penable", Penable, 1);
        chk("wr_en_hready", Hreadyout, 1);
        chk("wr_en_pwdata", Pwdata, 32'h1234_5678);
        cyc();
        chk("wr_idle_psel", Pselx, 0);
        chk("wr_idle_pwdata_hold", Pwdata, 32'h1234_5678);

        // write then read, back to back
        valid = 1'b1; Haddr = 32'h8000_0000; Hwrite = 1'b1; tempselx = 32'h1;
        cyc();
        Hwdata = 32'hA5A5_A5A5; Hwrite = 1'b0;
        chk("wr2_wait_hready", Hreadyout, 0);
        cyc();
        chk("wr2_setup_psel", Pselx, 1);
        chk("wr2_setup_pwdata", Pwdata, 32'hA5A5_A5A5);
        chk("wr2_setup_penable", Penable, 0);
        cyc();
        chk("wr2_en_penable", Penable, 1);
        chk("wr2_en_hready", Hreadyout, 1);
        cyc();
        valid = 1'b0; tempselx = 0; Prdata = 32'hCAFE_F00D;
        chk("rd2_setup_psel", Pselx, 1);
        chk("rd2_setup_penable", Penable, 0);
        chk("rd2_setup_pwrite", Pwrite, 0);
        chk("rd2_setup_paddr", Paddr, 32'h8000_0000);
        cyc();
        chk("rd2_en_penable", Penable, 1);
        chk("rd2_en_hrdata", Hrdata, 32'hCAFE_F00D);
        cyc();
        chk("rd2_idle_psel", Pselx, 0);

        // four consecutive reads
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; Hwrite = 1'b0; tempselx = 32'h4; Haddr = 32'h8800_0000 + 32'(4 * i);
            cyc();
            Prdata = 32'h1000 + 32'(i);
            chk($sformatf("burst%0d_setup_paddr", i), Paddr, 32'h8800_0000 + 64'(4 * i));
            chk($sformatf("burst%0d_setup_penable", i), Penable, 0);
            chk($sformatf("burst%0d_setup_hready", i), Hreadyout, 0);
            cyc();
            chk($sformatf("burst%0d_en_penable", i), Penable, 1);
            chk($sformatf("burst%0d_en_hready", i), Hreadyout, 1);
            chk($sformatf("burst%0d_en_hrdata", i), Hrdata, 64'h1000 + 64'(i));
            chk($sformatf("burst%0d_en_psel", i), Pselx, 4);
        end
        valid = 1'b0; tempselx = 0;
        cyc();
        chk("burst_idle_psel", Pselx, 0);
        chk("burst_idle_penable", Penable, 0);

        // reset while in WR_SETUP
        valid = 1'b1; Haddr = 32'h8000_0040; Hwrite = 1'b1; tempselx = 32'h1;
        cyc();
        valid = 1'b0; tempselx = 0; Hwrite = 1'b0; Hwdata = 32'h1111_2222;
        cyc();
        chk("rstw_setup_psel", Pselx, 1);
        Hresetn = 1'b0;
        #1;
        chk("rstw_psel", Pselx, 0);
        chk("rstw_penable", Penable, 0);
        chk("rstw_hready", Hreadyout, 1);
        chk("rstw_pwdata", Pwdata, 0);
        cyc();
        Hresetn = 1'b1;
        cyc();
        chk("rstw_noresume_psel", Pselx, 0);
        chk("rstw_noresume_penable", Penable, 0);
        valid = 1'b1; Haddr = 32'h8000_0050; Hwrite = 1'b0; tempselx = 32'h8; Prdata = 32'h0BAD_F00D;
        cyc();
        valid = 1'b0; tempselx = 0;
        chk("rstw_new_psel", Pselx, 8);
        chk("rstw_new_paddr", Paddr, 32'h8000_0050);
        chk("rstw_new_penable", Penable, 0);
        cyc();
        chk("rstw_new_en_penable", Penable, 1);
        chk("rstw_new_hrdata", Hrdata, 32'h0BAD_F00D);
        chk("rstw_hresp", Hresp, 0);
        cyc();
        chk("rstw_new_idle_psel", Pselx, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
Bridge-side APB master controller, directly upstream of the APB bus/interface. It consumes decoded AHB transfers from the AHB slave stage and drives Pselx/Penable/Pwrite/Paddr/Pwdata, captures Prdata back to Hrdata, and stalls AHB via Hreadyout. The APB side has no Pready, so every APB transfer is exactly SETUP+ENABLE (2 cycles).

Parameters:
ADDR_W, 32, Haddr/Paddr width
DATA_W, 32, Hwdata/Hrdata/Pwdata/Prdata width
PSEL_W, 32, Pselx width; one-hot slave select, unused bits 0

Ports:
Hclk  input  1  bridge clock, all state on rising edge
Hresetn  input  1  asynchronous active-low reset
valid  input  1  AHB stage: legal NONSEQ/SEQ transfer to bridge region this address phase
Haddr  input  ADDR_W  AHB address-phase address
Hwrite  input  1  AHB address-phase direction (1=write)
Hwdata  input  DATA_W  AHB write data (data phase)
tempselx  input  PSEL_W  one-hot slave select decoded from Haddr
Prdata  input  DATA_W  APB read data, valid in ENABLE cycle
Pselx  output  PSEL_W  APB select
Penable  output  1  APB enable
Pwrite  output  1  APB direction
Paddr  output  ADDR_W  APB address
Pwdata  output  DATA_W  APB write data
Hreadyout  output  1  1=AHB cycle completes / new address accepted
Hrdata  output  DATA_W  read data to AHB
Hresp  output  2  always OKAY (2'b00)

Behaviour:
- Reset (async, any state): state=IDLE; Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, Hrdata=0, Hresp=0. In-flight transfer silently dropped; no partial APB cycle resumes.
- APB outputs registered (Moore, glitch-free). Hreadyout, Hrdata decoded from state.
- Accept point: valid/Haddr/Hwrite/tempselx sampled only when Hreadyout=1 (IDLE, RD_ENABLE, WR_ENABLE). Accept requires valid=1 and tempselx!=0; otherwise treated as idle.
- On accept: latch Haddr->addr_q, tempselx->sel_q. Read -> RD_SETUP; write -> WWAIT.
- States / outputs / transitions:
  IDLE: Hreadyout=1, Psel=0, Penable=0. Accept as above, else stay.
  WWAIT: Hreadyout=0 (write data-phase wait); latch Hwdata->wdata_q; -> WR_SETUP.
  WR_SETUP: Pselx=sel_q, Paddr=addr_q, Pwrite=1, Pwdata=wdata_q, Penable=0; Hreadyout=0; -> WR_ENABLE.
  WR_ENABLE: Penable=1, other APB outputs held; Hreadyout=1 (write completes); accept check -> RD_SETUP / WWAIT / IDLE.
  RD_SETUP: Pselx=sel_q, Paddr=addr_q, Pwrite=0, Penable=0; Hreadyout=0; -> RD_ENABLE.
  RD_ENABLE: Penable=1; Hreadyout=1; Hrdata=Prdata (combinational pass-through this cycle; 0 in all other states); accept check as WR_ENABLE.
- Latency: read = accept + 2 data-phase cycles (1 AHB wait state); write = accept + 3 (2 wait states). Back-to-back: read every 2 cycles, write every 3, no idle APB cycle between.
- Leaving ENABLE to IDLE: Pselx=0, Penable=0 next cycle; Paddr/Pwdata/Pwrite hold last value.
- Master holds next address during wait states (Hreadyout=0); it is sampled only at the ENABLE cycle, so no pipeline buffer exists.
- Hresp constant OKAY; no error generation.

Decomposition:
- bridge_pkg: state enum (IDLE, WWAIT, WR_SETUP, WR_ENABLE, RD_SETUP, RD_ENABLE), HRESP_OKAY=2'b00, default widths.
- Single module; no sub-module (capture registers and FSM are small and tightly coupled).

Test Plan:
- Reset mid-WR_SETUP (Hresetn low 1 cycle) -> same cycle Pselx=0, Penable=0, Hreadyout=1; next accept starts clean SETUP.
- Single read Haddr=0x8000_0010, tempselx=0x1, Prdata=0xDEAD_BEEF -> RD_SETUP: Pselx=1, Paddr=0x8000_0010, Pwrite=0, Penable=0; RD_ENABLE: Penable=1, Hreadyout=1, Hrdata=0xDEAD_BEEF.
- Single write Haddr=0x8400_0004, tempselx=0x2, Hwdata=0x1234_5678 -> Hreadyout low 2 cycles; WR_SETUP Pwdata=0x1234_5678, Pwrite=1, Pselx=2; Penable=1 following cycle.
- Write then read back-to-back (0x8000_0000 wr 0xA5A5_A5A5, then rd 0x8000_0000) -> Pselx stays 1 across boundary, Penable 1->0->1, no idle APB cycle.
- valid=1 with tempselx=0 in IDLE -> no APB activity, Hreadyout stays 1.
- Four consecutive reads to 0x8800_0000..0x8800_000C -> Penable toggles every cycle, Hreadyout pattern 0,1 repeating, Paddr increments by 4.
